// File: rtl/unpacker_if.sv
// AXI4-Stream word channel carrying packed 24-bit RGB, 32 bits per beat.
// master drives the words, slave returns tready.
interface unpacker_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/unpacker.sv
// Unpacks 3 words of packed RGB into 4 pixels, one per beat,
// carrying start-of-frame and end-of-line through to the pixel side.
module unpacker (
    input  logic        aclk,
    input  logic        aresetn,
    unpacker_if.slave   in_stream,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        valid,
    output logic        eol,
    output logic        sof,
    input  logic        pixel_ready
);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t      phase, phase_n;
    logic [23:0] hold, hold_n;
    logic [23:0] pix, pix_n;
    logic        last_q, last_n;
    logic        valid_n, eol_n, sof_n;
    logic        load, take;
    logic [31:0] w;
    logic        unused_keep;

    assign unused_keep = ^in_stream.tkeep;

    assign load = !valid | pixel_ready;
    assign in_stream.tready = aresetn & load & (phase != PH3);
    assign take = in_stream.tvalid & in_stream.tready;
    assign w = in_stream.tdata;
    assign {r, g, b} = pix;

    always_comb begin
        phase_n = phase;
        hold_n  = hold;
        last_n  = last_q;
        pix_n   = pix;
        valid_n = valid;
        eol_n   = eol;
        sof_n   = sof;
        if (load) begin
            valid_n = 1'b0;
            eol_n   = 1'b0;
            sof_n   = 1'b0;
            // tuser on any word restarts decoding as if at phase 0
            unique case (1'b1)
                phase == PH3: begin
                    pix_n   = {hold[7:0], hold[15:8], hold[23:16]};
                    valid_n = 1'b1;
                    eol_n   = last_q;
                    last_n  = 1'b0;
                    phase_n = PH0;
                end
                take && (phase == PH0 || in_stream.tuser): begin
                    pix_n   = {w[7:0], w[15:8], w[23:16]};
                    valid_n = 1'b1;
                    sof_n   = in_stream.tuser;
                    hold_n  = {16'h0, w[31:24]};
                    phase_n = PH1;
                end
                take && phase == PH1 && !in_stream.tuser: begin
                    pix_n   = {hold[7:0], w[7:0], w[15:8]};
                    valid_n = 1'b1;
                    hold_n  = {8'h0, w[31:16]};
                    phase_n = PH2;
                end
                take && phase == PH2 && !in_stream.tuser: begin
                    pix_n   = {hold[7:0], hold[15:8], w[7:0]};
                    valid_n = 1'b1;
                    hold_n  = w[31:8];
                    last_n  = in_stream.tlast;
                    phase_n = PH3;
                end
                default: ;
            endcase
            // short line: end it here and drop the partial pixel bytes
            if (take && in_stream.tlast && phase_n != PH3) begin
                eol_n   = 1'b1;
                hold_n  = 24'h0;
                phase_n = PH0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase  <= PH0;
            hold   <= 24'h0;
            last_q <= 1'b0;
            pix    <= 24'h0;
            valid  <= 1'b0;
            eol    <= 1'b0;
            sof    <= 1'b0;
        end else begin
            phase  <= phase_n;
            hold   <= hold_n;
            last_q <= last_n;
            pix    <= pix_n;
            valid  <= valid_n;
            eol    <= eol_n;
            sof    <= sof_n;
        end
    end

endmodule

// File: tb/tb_unpacker.sv
// Bench for unpacker: byte-queue reference model, directed and
// randomized streams, backpressure and asynchronous reset.
module tb_unpacker;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] r, g, b;
    logic       valid, eol, sof;
    logic       pixel_ready;

    unpacker_if s ();

    unpacker dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_stream   (s),
        .r           (r),
        .g           (g),
        .b           (b),
        .valid       (valid),
        .eol         (eol),
        .sof         (sof),
        .pixel_ready (pixel_ready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit stab_en = 0;

    // pixel = {sof, eol, r, g, b}
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    int          got_cyc[$];
    logic [7:0]  bq[$];
    bit          sp = 0;

    logic [25:0] want[4];
    logic [25:0] prev;
    bit          prev_hold = 0;

    always @(posedge aclk) cyc++;

    initial begin
        pixel_ready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0: pixel_ready = 1'b1;
                1: pixel_ready = !pixel_ready;
                2: pixel_ready = ($urandom % 100) < 70;
                default: pixel_ready = 1'b0;
            endcase
        end
    end

    always @(negedge aclk) begin
        if (stab_en && prev_hold) begin
            checks++;
            if (!valid || {sof, eol, r, g, b} !== prev) begin
                errors++;
                $display("FAIL hold_stable got v=%0b %h want %h",
                         valid, {sof, eol, r, g, b}, prev);
            end
        end
        prev_hold = aresetn && valid && !pixel_ready;
        prev = {sof, eol, r, g, b};
        if (aresetn && valid && pixel_ready) begin
            got_q.push_back({sof, eol, r, g, b});
            got_cyc.push_back(cyc);
        end
    end

    // Reference: the line is a byte stream cut into r,g,b triples.
    task automatic model_word(input logic [31:0] d,
                              input logic u, input logic l);
        if (u) begin
            bq.delete();
            sp = 1;
        end
        for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
        while (bq.size() >= 3) begin
            exp_q.push_back({sp, 1'b0, bq[0], bq[1], bq[2]});
            sp = 0;
            void'(bq.pop_front());
            void'(bq.pop_front());
            void'(bq.pop_front());
        end
        if (l) begin
            exp_q[exp_q.size() - 1][24] = 1'b1;
            bq.delete();
        end
    endtask

    task automatic send_word(input logic [31:0] d,
                             input logic u, input logic l);
        bit ok;
        s.tdata  = d;
        s.tuser  = u;
        s.tlast  = l;
        s.tkeep  = 4'hf;
        s.tvalid = 1'b1;
        model_word(d, u, l);
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge aclk);
            if (s.tready) ok = 1;
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout word %h got tready=0 want 1", d);
        end
    endtask

    task automatic drain();
        s.tvalid = 1'b0;
        for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++)
            @(negedge aclk);
        repeat (6) @(negedge aclk);
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        #1 aresetn = 1'b0;
        s.tvalid = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if (s.tready !== 1'b0) begin
            errors++;
            $display("FAIL rst_tready got %b want 0", s.tready);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", valid);
        end
        checks++;
        if ({eol, sof} !== 2'b00) begin
            errors++;
            $display("FAIL rst_flags got %b want 00", {eol, sof});
        end
        checks++;
        if ({r, g, b} !== 24'h0) begin
            errors++;
            $display("FAIL rst_rgb got %h want 000000", {r, g, b});
        end
        s.tvalid = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic();
        rdy_mode = 0;
        send_word(32'h44332211, 1'b1, 1'b0);
        send_word(32'h88776655, 1'b0, 1'b0);
        send_word(32'hCCBBAA99, 1'b0, 1'b1);
        s.tvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (s.tready !== 1'b0) begin
            errors++;
            $display("FAIL basic_tready_ph3 got %b want 0", s.tready);
        end
        drain();
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin
                errors++;
                $display("FAIL basic_pix%0d got %h want %h",
                         i, got_q[i], want[i]);
            end
        end
        if (got_q.size() == 4) begin
            checks++;
            if (got_cyc[3] - got_cyc[0] != 3) begin
                errors++;
                $display("FAIL basic_span got %0d cycles want 3",
                         got_cyc[3] - got_cyc[0]);
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        stab_en = 1;
        send_word(32'h44332211, 1'b1, 1'b0);
        send_word(32'h88776655, 1'b0, 1'b0);
        send_word(32'hCCBBAA99, 1'b0, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL bp_count got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== want[i]) begin
                errors++;
                $display("FAIL bp_pix%0d got %h want %h",
                         i, got_q[i], want[i]);
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        rdy_mode = 0;
        for (int l = 0; l < 2; l++)
            for (int w = 0; w < 6; w++)
                send_word($urandom, l == 0 && w == 0, w == 5);
        drain();
        checks++;
        if (got_q.size() != 16 || exp_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_count got %0d want 16", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_pix%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_resync();
        logic [25:0] rw[4];
        rw[0] = 26'h2112233;
        rw[1] = 26'h2090A0B;
        rw[2] = 26'h10C0D0E;
        rw[3] = 26'h1141516;
        rdy_mode = 2;
        send_word(32'h44332211, 1'b1, 1'b0);
        send_word(32'h0C0B0A09, 1'b1, 1'b0);
        send_word(32'h100F0E0D, 1'b0, 1'b1);
        send_word(32'h17161514, 1'b0, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL resync_count got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== rw[i]) begin
                errors++;
                $display("FAIL resync_pix%0d got %h want %h",
                         i, got_q[i], rw[i]);
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int gap;
        rdy_mode = 2;
        for (int n = 0; n < 150; n++) begin
            send_word($urandom, ($urandom % 8) == 0,
                      ($urandom % 5) == 0);
            gap = $urandom % 3;
            if (gap > 0) begin
                s.tvalid = 1'b0;
                repeat (gap) @(posedge aclk);
                #1;
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_pix%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        rdy_mode = 0;
        send_word(32'h44332211, 1'b1, 1'b0);
        send_word(32'h88776655, 1'b0, 1'b0);
        stab_en = 0;
        rdy_mode = 3;
        pixel_ready = 1'b0;
        s.tvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid got %b want 1", valid);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({valid, eol, sof} !== 3'b000) begin
            errors++;
            $display("FAIL mid_rst_flags got %b want 000",
                     {valid, eol, sof});
        end
        checks++;
        if ({r, g, b} !== 24'h0) begin
            errors++;
            $display("FAIL mid_rst_rgb got %h want 000000", {r, g, b});
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        bq.delete();
        sp = 0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        rdy_mode = 0;
        pixel_ready = 1'b1;
        send_word(32'h44332211, 1'b0, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL mid_count got %0d want 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 26'h1112233) begin
                errors++;
                $display("FAIL mid_pix got %h want 1112233", got_q[0]);
            end
        end
    endtask

    initial begin
        want[0] = 26'h2112233;
        want[1] = 26'h0445566;
        want[2] = 26'h0778899;
        want[3] = 26'h1AABBCC;
        aresetn  = 1'b1;
        s.tvalid = 1'b0;
        s.tdata  = 32'h0;
        s.tuser  = 1'b0;
        s.tlast  = 1'b0;
        s.tkeep  = 4'hf;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_resync();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unpacker.md
# unpacker

Converts a 32-bit AXI4-Stream video stream carrying packed 24-bit RGB (byte order r,g,b, little-endian within each word, 3 words per 4 pixels) into a one-pixel-per-beat r/g/b stream with valid/ready, start-of-frame and end-of-line flags. It sits on the receive side of the video pipeline, between the DMA/VDMA read stream and pixel-processing logic. It is the inverse of the team's pixel packer.

## Interface
- No parameters.
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- in_stream_tdata  in  32  packed pixel bytes
- in_stream_tkeep  in  4  ignored; always 4'hf by contract
- in_stream_tlast  in  1  last word of a line
- in_stream_tuser  in  1  first word of a frame
- in_stream_tvalid  in  1  input word valid
- in_stream_tready  out  1  input word accepted when tvalid & tready
- r, g, b  out  8 each  pixel colour, registered
- valid  out  1  pixel valid, registered
- eol  out  1  pixel is last of line, registered
- sof  out  1  pixel is first of frame, registered
- pixel_ready  in  1  downstream accepts pixel when valid & pixel_ready

## Operation
- Byte stream r0 g0 b0 r1 g1 b1 r2 g2 b2 r3 g3 b3 maps to W0 = {r1,b0,g0,r0}, W1 = {g2,r2,b1,g1}, W2 = {b3,g3,r3,b2}.
- State: 2-bit phase (0..3), 24-bit hold register, one output pixel register (r,g,b,valid,eol,sof).
- load = !valid | pixel_ready (output register free this cycle).
- in_stream_tready = aresetn-released & load & (phase != 3).
- Phase 0, word accepted: pixel = {W[7:0],W[15:8],W[23:16]}; hold[7:0] <= W[31:24]; phase -> 1.
- Phase 1, word accepted: pixel = {hold[7:0],W[7:0],W[15:8]}; hold[15:0] <= W[31:16]; phase -> 2.
- Phase 2, word accepted: pixel = {hold[7:0],hold[15:8],W[7:0]}; hold <= W[31:8]; phase -> 3.
- Phase 3, load true: pixel = hold bytes {r,g,b} = {hold[7:0],hold[15:8],hold[23:16]}; no input consumed; phase -> 0.
- sof: set on the pixel produced from a phase-0 word with tuser=1; 0 on all others.
- tuser=1 on a word accepted in phase 1 or 2: resynchronise — discard hold, decode the word as phase 0 (sof=1), phase -> 1.
- tlast on phase-2 word: pixel 2 eol=0; tlast remembered; phase-3 pixel eol=1; phase -> 0.
- tlast on phase-0 or phase-1 word (length not multiple of 4): that pixel eol=1, hold discarded, phase -> 0.
- When load is true and no pixel is produced, valid <= 0.
- tkeep not checked.

## Timing
- Reset (aresetn low, asynchronous): phase=0, hold=0, r=g=b=0, valid=0, eol=0, sof=0, tlast flag=0; in_stream_tready=0 while reset asserted.
- Latency: pixel valid 1 cycle after word accept edge; phase-3 pixel valid 1 cycle after phase-2 pixel is produced (if load).
- Throughput with pixel_ready=1: 4 pixels per 4 cycles, 3 words; tready low exactly one cycle in four.
- Backpressure: pixel_ready=0 with valid=1 holds r/g/b/eol/sof/valid stable and drops tready same cycle (combinational).
- Reset mid-line: all state discarded; first accepted word after release decoded as phase 0.
- tvalid low in phases 0-2: phase and hold unchanged, valid deasserts once current pixel accepted.

## Test plan
- Words 0x44332211, 0x88776655, 0xCCBBAA99 (tuser on first, tlast on third), pixel_ready=1 -> pixels (11,22,33) sof=1, (44,55,66), (77,88,99), (AA,BB,CC) eol=1 on 4 consecutive cycles; tready low the cycle of the 4th pixel load.
- Same stream with pixel_ready toggling 1,0,1,0 -> identical pixel sequence, each held stable while pixel_ready=0, no word lost or duplicated.
- Two lines of 8 pixels (6 words each) back-to-back -> 16 pixels, eol on pixels 8 and 16 only, sof on pixel 1 only.
- tuser=1 on a phase-1 word 0x0C0B0A09 -> pixel (09,0A,0B) with sof=1, phase continues at 1; prior residual byte dropped.
- tlast on phase-1 word -> that pixel eol=1; next word decoded as phase 0.
- Assert aresetn low while phase=2 and valid=1 -> valid, eol, sof, r/g/b go 0 immediately; after release, 0x44332211 yields (11,22,33).
